ep0_desc_streamer: RTL and testbench
====================================

Name: ep0_desc_streamer

Overview:
- Sequential successor to the EP0 descriptor ROM. Turns a decoded GET_DESCRIPTOR request (type, index, wLength) into a byte stream packetised to the EP0 max packet size.
- Looks up start and end offsets in the descriptor start LUT and drives the ROM read address.
- Sits between the EP0 control state machine and the IN packet serializer.
- Supports per-packet ACK/retry rewind, wLength truncation and zero-length packet (ZLP) termination.

Parameters:
- ROM_IDX_WID, 9, width of ROM byte address.
- NUM_CONFS, 1, number of configuration descriptors in ROM.
- NUM_STRS, 4, number of string descriptors, including string zero.
- MAX_PACKET_SIZE, 64, EP0 max packet size in bytes; legal values 8, 16, 32, 64.
- NUM_LUT, 1+NUM_CONFS+NUM_STRS+1, number of LUT entries; the last entry is the ROM end.

Ports:
- clk12_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request strobe; sampled only in IDLE
- descType_i  in  8  descriptor type: 1 device, 2 config, 3 string
- descIdx_i  in  8  descriptor index
- wLength_i  in  16  host-requested length
- abort_i  in  1  new SETUP or bus reset; aborts the transfer
- descStartLut_i  in  NUM_LUT*ROM_IDX_WID  flattened start offsets, entry k at bits [k*ROM_IDX_WID +: ROM_IDX_WID]
- romAddr_o  out  ROM_IDX_WID  ROM read address
- romData_i  in  8  ROM read data
- data_o  out  8  stream byte
- valid_o  out  1  data_o valid
- ready_i  in  1  consumer accepts the byte
- pktLast_o  out  1  current byte is the last byte of its packet
- pktEnd_o  out  1  packet complete, waiting for host result
- pktZlp_o  out  1  the pending packet has zero length; valid only while pktEnd_o is high
- pktAck_i  in  1  host ACKed the packet
- pktRetry_i  in  1  packet lost or timed out; resend it
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when the final packet is ACKed
- stall_o  out  1  one-cycle pulse when the request is invalid

Behaviour:
- Reset values: all outputs 0, state IDLE, romAddr_o = 0.
- LUT index mapping:
  - type 1, index 0 → entry 0.
  - type 2, index n < NUM_CONFS → entry 1+n.
  - type 3, index n < NUM_STRS → entry 1+NUM_CONFS+n.
  - Any other combination → stall_o pulse one cycle after start_i; stay IDLE.
- Length arithmetic:
  - descLen = lut[k+1] - lut[k], ROM_IDX_WID+1 bits, unsigned.
  - xferLen = min(descLen, wLength_i), 16 bits.
  - needZlp = (xferLen < wLength_i) && (xferLen % MAX_PACKET_SIZE == 0) && (xferLen != 0).
  - wLength_i == 0 → done_o pulses in LOOKUP; no packets are sent.
- States:
  - IDLE: start_i with a valid request → LOOKUP.
  - LOOKUP (1 cycle): latch pktStart = curAddr = lut[k] and remaining = xferLen → STREAM.
  - STREAM:
    - valid_o = 1, data_o = romData_i at romAddr_o = curAddr.
    - A byte transfers on valid_o && ready_i: curAddr++, remaining--, pktCnt++.
    - pktLast_o = 1 when pktCnt == MAX_PACKET_SIZE-1 or remaining == 1.
    - After the last byte transfers → PKT_END.
  - PKT_END: pktEnd_o = 1.
    - pktRetry_i → curAddr = pktStart, remaining and pktCnt restored → STREAM, or back to PKT_END if the packet was the ZLP.
    - pktAck_i with remaining > 0 → pktStart = curAddr, pktCnt = 0 → STREAM.
    - pktAck_i with remaining == 0 and needZlp pending → PKT_END again with pktZlp_o = 1, needZlp cleared.
    - pktAck_i otherwise → done_o pulse → IDLE.
    - pktAck_i and pktRetry_i together → treated as retry.
- abort_i has priority in every state: next cycle IDLE; valid_o, pktEnd_o and busy_o go to 0; done_o and stall_o are not pulsed.
- busy_o is 1 in LOOKUP, STREAM and PKT_END.
- valid_o never drops without a transfer, except on abort_i or rst_i.
- data_o is stable while valid_o && !ready_i.
- Address wrap is not permitted; curAddr never exceeds lut[k+1]-1.

Optional Feature:
- Macro: EP0_DESC_SYNC_ROM_EN.
- Defined: the ROM is a synchronous BRAM whose data lags romAddr_o by 1 cycle.
  - The streamer keeps a 1-entry prefetch/skid register. romAddr_o runs one byte ahead of the byte on data_o.
  - Entering STREAM, or re-entering it after retry, adds 1 cycle before valid_o rises.
  - Throughput stays 1 byte/cycle with ready_i held high.
- Undefined: combinational ROM read; valid_o rises the cycle after LOOKUP or after pktAck_i/pktRetry_i.

Test Plan:
- Device descriptor (lut0 = 0, lut1 = 18), wLength 64, MPS 64 → 18 bytes from ROM 0..17, pktLast_o on byte 18, no ZLP; pktAck_i → done_o.
- Config descriptor of 34 bytes, wLength 255, MPS 8 → packets of 8,8,8,8,2; each needs pktAck_i; done_o after the 5th ACK.
- Config of 32 bytes, wLength 255, MPS 16 → packets of 16,16, then a ZLP (pktEnd_o = 1, pktZlp_o = 1); ACK → done_o. Repeat with wLength 32 → no ZLP.
- Second packet answered with pktRetry_i, then the same packet with both pktAck_i and pktRetry_i high → identical bytes resent twice; third attempt ACKed advances.
- String index 9 with NUM_STRS 4 → stall_o pulse, busy_o stays 0. wLength 0 → done_o with no valid_o.
- abort_i mid-STREAM with ready_i toggling → IDLE next cycle. A new start_i for the device descriptor then streams from address 0.

Source files
------------

// File: rtl/ep0_desc_streamer.sv
// EP0 descriptor streamer: turns a decoded GET_DESCRIPTOR request into a
// byte stream cut into max-packet-size packets, with per-packet ACK/retry,
// wLength truncation and zero-length-packet termination.
// Build option: define EP0_DESC_SYNC_ROM_EN for a synchronous (1-cycle) ROM.
module ep0_desc_streamer #(
  parameter int unsigned ROM_IDX_WID     = 9,
  parameter int unsigned NUM_CONFS       = 1,
  parameter int unsigned NUM_STRS        = 4,
  parameter int unsigned MAX_PACKET_SIZE = 64,
  parameter int unsigned NUM_LUT         = 1 + NUM_CONFS + NUM_STRS + 1
) (
  input  logic                           clk12_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [7:0]                     descType_i,
  input  logic [7:0]                     descIdx_i,
  input  logic [15:0]                    wLength_i,
  input  logic                           abort_i,
  input  logic [NUM_LUT*ROM_IDX_WID-1:0] descStartLut_i,
  output logic [ROM_IDX_WID-1:0]         romAddr_o,
  input  logic [7:0]                     romData_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           pktLast_o,
  output logic                           pktEnd_o,
  output logic                           pktZlp_o,
  input  logic                           pktAck_i,
  input  logic                           pktRetry_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           stall_o
);

  localparam int unsigned KW  = $clog2(NUM_LUT);
  localparam int unsigned MW  = $clog2(MAX_PACKET_SIZE);
  localparam int unsigned PCW = MW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_STREAM, S_PKT_END} state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q;
  logic [15:0]            wlen_q;
  logic [ROM_IDX_WID-1:0] cur_addr_q, pkt_start_q;
  logic [15:0]            remaining_q, rem_start_q;
  logic [PCW-1:0]         pkt_cnt_q;
  logic                   need_zlp_q, zlp_q, done_q, stall_q;

  logic                   req_ok;
  logic [KW-1:0]          req_k;
  logic [ROM_IDX_WID-1:0] lut_start, lut_end;
  logic [ROM_IDX_WID:0]   desc_len;
  logic [15:0]            xfer_len;
  logic                   need_zlp_c, last_c, xfer_c;

  // Map (type, index) onto a descriptor LUT entry
  always_comb begin
    req_ok = 1'b0;
    req_k  = '0;
    case (descType_i)
      8'd1: if (descIdx_i == 8'd0) begin
        req_ok = 1'b1;
      end
      8'd2: if (32'(descIdx_i) < NUM_CONFS) begin
        req_ok = 1'b1;
        req_k  = KW'(32'd1 + 32'(descIdx_i));
      end
      8'd3: if (32'(descIdx_i) < NUM_STRS) begin
        req_ok = 1'b1;
        req_k  = KW'(32'd1 + NUM_CONFS + 32'(descIdx_i));
      end
      default: ;
    endcase
  end

  // Descriptor bounds, truncated transfer length and ZLP requirement
  always_comb begin
    lut_start  = descStartLut_i[32'(k_q) * ROM_IDX_WID +: ROM_IDX_WID];
    lut_end    = descStartLut_i[(32'(k_q) + 32'd1) * ROM_IDX_WID +: ROM_IDX_WID];
    desc_len   = {1'b0, lut_end} - {1'b0, lut_start};
    xfer_len   = (16'(desc_len) < wlen_q) ? 16'(desc_len) : wlen_q;
    need_zlp_c = (xfer_len < wlen_q) && (xfer_len[MW-1:0] == '0) && (xfer_len != 16'd0);
    last_c     = (pkt_cnt_q == PCW'(MAX_PACKET_SIZE - 1)) || (remaining_q == 16'd1);
    xfer_c     = valid_o && ready_i;
  end

`ifdef EP0_DESC_SYNC_ROM_EN
  logic [ROM_IDX_WID-1:0] fetch_q;
  logic [PCW-1:0]         fetch_left_q;
  logic                   rv_q, skid_v_q, skid_v_nx, skid_ld, issue;
  logic [7:0]             skid_q;

  function automatic logic [PCW-1:0] pkt_len(input logic [15:0] r);
    return (r >= 16'(MAX_PACKET_SIZE)) ? PCW'(MAX_PACKET_SIZE) : PCW'(r);
  endfunction

  // Skid occupancy; a new ROM read issues only when its data is sure to have a slot
  always_comb begin
    skid_v_nx = skid_v_q ? (xfer_c ? rv_q : 1'b1) : (rv_q && !xfer_c);
    skid_ld   = skid_v_q ? (xfer_c && rv_q) : (rv_q && !xfer_c);
    issue     = (state_q == S_STREAM) && !skid_v_nx && (fetch_left_q != '0);
  end

  // Prefetch address, in-flight read flag and skid register
  always_ff @(posedge clk12_i) begin
    if (rst_i || abort_i) begin
      fetch_q      <= '0;
      fetch_left_q <= '0;
      rv_q         <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_q       <= '0;
    end else begin
      rv_q     <= issue;
      skid_v_q <= (state_q == S_STREAM) && skid_v_nx;
      if (skid_ld) skid_q <= romData_i;
      if (state_q == S_LOOKUP) begin
        fetch_q      <= lut_start;
        fetch_left_q <= pkt_len(xfer_len);
      end else if (state_q == S_PKT_END && pktRetry_i) begin
        fetch_q      <= pkt_start_q;
        fetch_left_q <= pkt_len(rem_start_q);
      end else if (state_q == S_PKT_END && pktAck_i) begin
        fetch_q      <= cur_addr_q;
        fetch_left_q <= pkt_len(remaining_q);
      end else if (issue) begin
        fetch_q      <= fetch_q + ROM_IDX_WID'(fetch_left_q != PCW'(1));
        fetch_left_q <= fetch_left_q - PCW'(1);
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk12_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort wins over everything
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_i && req_ok) state_d = S_LOOKUP;
        S_LOOKUP: state_d = (xfer_len == 16'd0) ? S_IDLE : S_STREAM;
        S_STREAM: if (xfer_c && last_c) state_d = S_PKT_END;
        S_PKT_END: begin
          if (pktRetry_i)                  state_d = zlp_q ? S_PKT_END : S_STREAM;
          else if (pktAck_i) begin
            if (remaining_q != 16'd0)      state_d = S_STREAM;
            else if (need_zlp_q)           state_d = S_PKT_END;
            else                           state_d = S_IDLE;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    pktEnd_o  = (state_q == S_PKT_END);
    pktZlp_o  = (state_q == S_PKT_END) && zlp_q;
    done_o    = done_q;
    stall_o   = stall_q;
`ifdef EP0_DESC_SYNC_ROM_EN
    romAddr_o = fetch_q;
    valid_o   = (state_q == S_STREAM) && (skid_v_q || rv_q);
    data_o    = valid_o ? (skid_v_q ? skid_q : romData_i) : 8'h00;
`else
    romAddr_o = cur_addr_q;
    valid_o   = (state_q == S_STREAM);
    data_o    = valid_o ? romData_i : 8'h00;
`endif
    pktLast_o = valid_o && last_c;
  end

  // Transfer bookkeeping: addresses, byte counts, ZLP tracking and pulses
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      k_q         <= '0;
      wlen_q      <= '0;
      cur_addr_q  <= '0;
      pkt_start_q <= '0;
      remaining_q <= '0;
      rem_start_q <= '0;
      pkt_cnt_q   <= '0;
      need_zlp_q  <= 1'b0;
      zlp_q       <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else if (abort_i) begin
      need_zlp_q  <= 1'b0;
      zlp_q       <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          if (req_ok) begin
            k_q    <= req_k;
            wlen_q <= wLength_i;
            done_q <= (wLength_i == 16'd0);
          end else begin
            stall_q <= 1'b1;
          end
        end
        S_LOOKUP: begin
          pkt_start_q <= lut_start;
          cur_addr_q  <= lut_start;
          remaining_q <= xfer_len;
          rem_start_q <= xfer_len;
          pkt_cnt_q   <= '0;
          need_zlp_q  <= need_zlp_c;
          zlp_q       <= 1'b0;
          done_q      <= (xfer_len == 16'd0) && (wlen_q != 16'd0);
        end
        S_STREAM: if (xfer_c) begin
          // Hold on the final byte so the address never leaves the descriptor
          cur_addr_q  <= cur_addr_q + ROM_IDX_WID'(remaining_q != 16'd1);
          remaining_q <= remaining_q - 16'd1;
          pkt_cnt_q   <= pkt_cnt_q + PCW'(1);
        end
        S_PKT_END: begin
          if (pktRetry_i) begin
            cur_addr_q  <= pkt_start_q;
            remaining_q <= rem_start_q;
            pkt_cnt_q   <= '0;
          end else if (pktAck_i) begin
            if (remaining_q != 16'd0) begin
              pkt_start_q <= cur_addr_q;
              rem_start_q <= remaining_q;
              pkt_cnt_q   <= '0;
            end else if (need_zlp_q) begin
              need_zlp_q  <= 1'b0;
              zlp_q       <= 1'b1;
            end else begin
              done_q      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ep0_desc_streamer.sv
// Directed bench for ep0_desc_streamer (combinational ROM build, MPS 8).
module tb_ep0_desc_streamer;

  localparam int unsigned RW  = 9;
  localparam int unsigned MPS = 8;
  localparam int unsigned NL  = 8;

  logic          clk12_i = 1'b0;
  logic          rst_i, start_i, abort_i, ready_i, pktAck_i, pktRetry_i;
  logic [7:0]    descType_i, descIdx_i, romData_i, data_o;
  logic [15:0]   wLength_i;
  logic [NL*RW-1:0] lut;
  logic [RW-1:0] romAddr_o;
  logic          valid_o, pktLast_o, pktEnd_o, pktZlp_o, busy_o, done_o, stall_o;

  int checks = 0;
  int errors = 0;

  // dev 0..18, conf0 18..52 (34), conf1 52..84 (32), strings 84/88/100/110, end 120
  assign lut = {9'd120, 9'd110, 9'd100, 9'd88, 9'd84, 9'd52, 9'd18, 9'd0};

  function automatic logic [7:0] rom_byte(input logic [RW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd7;
    return t[7:0] ^ 8'h3C;
  endfunction

  assign romData_i = rom_byte(romAddr_o);

  always #5 clk12_i = ~clk12_i;

  ep0_desc_streamer #(
    .ROM_IDX_WID(RW), .NUM_CONFS(2), .NUM_STRS(4), .MAX_PACKET_SIZE(MPS)
  ) dut (
    .clk12_i(clk12_i), .rst_i(rst_i), .start_i(start_i), .descType_i(descType_i),
    .descIdx_i(descIdx_i), .wLength_i(wLength_i), .abort_i(abort_i),
    .descStartLut_i(lut), .romAddr_o(romAddr_o), .romData_i(romData_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .pktLast_o(pktLast_o),
    .pktEnd_o(pktEnd_o), .pktZlp_o(pktZlp_o), .pktAck_i(pktAck_i),
    .pktRetry_i(pktRetry_i), .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk12_i);
    #1;
  endtask

  task automatic answer(input logic ack, input logic retry);
    pktAck_i   = ack;
    pktRetry_i = retry;
    step();
    pktAck_i   = 1'b0;
    pktRetry_i = 1'b0;
  endtask

  // Collect one packet of n bytes starting at ROM address addr, then expect PKT_END
  task automatic recv_pkt(input string nm, input int addr, input int n, input bit tgl);
    int got_n;
    int cyc;
    logic r;
    got_n = 0;
    cyc   = 0;
    while (got_n < n && cyc < 200) begin
      r = tgl ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_i = r;
      if (valid_o) begin
        check_val({nm, "/data"}, 32'(data_o), 32'(rom_byte(RW'(addr + got_n))));
        check_val({nm, "/last"}, 32'(pktLast_o), 32'(got_n == n - 1));
        if (r) got_n++;
      end
      step();
      cyc++;
    end
    ready_i = 1'b0;
    check_val({nm, "/pkt_bytes"}, 32'(got_n), 32'(n));
    cyc = 0;
    while (!pktEnd_o && cyc < 10) begin
      step();
      cyc++;
    end
    check_val({nm, "/pkt_end"}, 32'(pktEnd_o), 32'd1);
    check_val({nm, "/pkt_zlp"}, 32'(pktZlp_o), 32'd0);
    check_val({nm, "/valid_in_end"}, 32'(valid_o), 32'd0);
  endtask

  // Full request: start, every packet (optional retry on one), ZLP, done
  task automatic run_xfer(input string nm, input int typ, input int idx, input int wlen,
                          input int base, input int dlen, input int retry_pkt, input bit tgl);
    int  xl, rem, addr, n, p;
    bit  zlp;
    xl  = (dlen < wlen) ? dlen : wlen;
    zlp = (xl < wlen) && (xl % MPS == 0) && (xl != 0);
    descType_i = 8'(typ);
    descIdx_i  = 8'(idx);
    wLength_i  = 16'(wlen);
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
    check_val({nm, "/busy_lookup"}, 32'(busy_o), 32'd1);
    check_val({nm, "/done_lookup"}, 32'(done_o), 32'(wlen == 0));
    check_val({nm, "/valid_lookup"}, 32'(valid_o), 32'd0);
    if (xl == 0) begin
      step();
      check_val({nm, "/busy_after"}, 32'(busy_o), 32'd0);
      check_val({nm, "/done_after"}, 32'(done_o), 32'd0);
      check_val({nm, "/valid_after"}, 32'(valid_o), 32'd0);
      return;
    end
    rem  = xl;
    addr = base;
    p    = 0;
    while (rem > 0) begin
      n = (rem < MPS) ? rem : MPS;
      recv_pkt(nm, addr, n, tgl);
      if (p == retry_pkt) begin
        answer(1'b0, 1'b1);
        recv_pkt({nm, "/retry"}, addr, n, tgl);
        answer(1'b1, 1'b1);
        recv_pkt({nm, "/ackretry"}, addr, n, tgl);
      end
      rem  -= n;
      addr += n;
      p++;
      answer(1'b1, 1'b0);
    end
    if (zlp) begin
      check_val({nm, "/zlp_end"}, 32'(pktEnd_o), 32'd1);
      check_val({nm, "/zlp_flag"}, 32'(pktZlp_o), 32'd1);
      check_val({nm, "/zlp_valid"}, 32'(valid_o), 32'd0);
      answer(1'b1, 1'b0);
    end
    check_val({nm, "/done"}, 32'(done_o), 32'd1);
    check_val({nm, "/busy_end"}, 32'(busy_o), 32'd0);
    check_val({nm, "/pkt_end_clr"}, 32'(pktEnd_o), 32'd0);
    step();
    check_val({nm, "/done_pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
    pktAck_i = 1'b0; pktRetry_i = 1'b0;
    descType_i = 8'd0; descIdx_i = 8'd0; wLength_i = 16'd0;
    repeat (3) step();
    check_val("rst/valid", 32'(valid_o), 32'd0);
    check_val("rst/busy", 32'(busy_o), 32'd0);
    check_val("rst/rom_addr", 32'(romAddr_o), 32'd0);
    check_val("rst/data", 32'(data_o), 32'd0);
    check_val("rst/done", 32'(done_o), 32'd0);
    check_val("rst/stall", 32'(stall_o), 32'd0);
    check_val("rst/pkt_end", 32'(pktEnd_o), 32'd0);
    rst_i = 1'b0;
    step();

    run_xfer("dev64",     1, 0,  64,   0, 18, -1, 1'b0);
    run_xfer("conf34",    2, 0, 255,  18, 34, -1, 1'b0);
    run_xfer("conf32zlp", 2, 1, 255,  52, 32, -1, 1'b0);
    run_xfer("conf32exact", 2, 1, 32, 52, 32, -1, 1'b0);
    run_xfer("retry",     2, 0, 255,  18, 34,  1, 1'b1);
    run_xfer("dev_trunc10", 1, 0, 10,  0, 18, -1, 1'b1);
    run_xfer("dev_trunc16", 1, 0, 16,  0, 18, -1, 1'b0);
    run_xfer("str2",      3, 2, 255, 100, 10, -1, 1'b0);
    run_xfer("str0",      3, 0, 255,  84,  4, -1, 1'b1);
    run_xfer("wlen0",     1, 0,   0,   0, 18, -1, 1'b0);

    // Invalid requests stall and never leave IDLE
    descType_i = 8'd3; descIdx_i = 8'd9; wLength_i = 16'd255; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_val("stall_str9/stall", 32'(stall_o), 32'd1);
    check_val("stall_str9/busy", 32'(busy_o), 32'd0);
    step();
    check_val("stall_str9/pulse", 32'(stall_o), 32'd0);
    check_val("stall_str9/busy2", 32'(busy_o), 32'd0);
    descType_i = 8'd1; descIdx_i = 8'd1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_val("stall_dev1/stall", 32'(stall_o), 32'd1);
    check_val("stall_dev1/busy", 32'(busy_o), 32'd0);
    step();

    // Abort mid-stream, then a fresh device request starts again at address 0
    descType_i = 8'd1; descIdx_i = 8'd0; wLength_i = 16'd64; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check_val("abort/streaming", 32'(valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      ready_i = 1'($urandom_range(0, 1));
      step();
    end
    abort_i = 1'b1;
    ready_i = 1'b1;
    step();
    abort_i = 1'b0;
    ready_i = 1'b0;
    check_val("abort/valid", 32'(valid_o), 32'd0);
    check_val("abort/busy", 32'(busy_o), 32'd0);
    check_val("abort/pkt_end", 32'(pktEnd_o), 32'd0);
    check_val("abort/done", 32'(done_o), 32'd0);
    check_val("abort/stall", 32'(stall_o), 32'd0);
    step();
    check_val("abort/done2", 32'(done_o), 32'd0);
    run_xfer("after_abort", 1, 0, 64, 0, 18, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
